// File: rtl/clint_pkg.sv
// Shared constants, state type and byte-merge helper for the CLINT block.
package clint_pkg;

    // Word addresses (byte address >> 2) inside the 64 KiB CLINT window.
    localparam logic [15:0] MSIP_ADR        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_ADR = 16'h1000;
    localparam logic [15:0] MTIMECMP_HI_ADR = 16'h1001;
    localparam logic [15:0] MTIME_LO_ADR    = 16'h2FFE;
    localparam logic [15:0] MTIME_HI_ADR    = 16'h2FFF;

    // All ones keeps the timer interrupt quiet until software programs a deadline.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE,
        ACK
    } clint_state_t;

    // Replace only the bytes of old_val whose select bit is set.
    function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_wb_timer_if.sv
// Wishbone-classic bus bundle between the CPU data port and the CLINT.
interface clint_wb_timer_if #(
    parameter int unsigned ADR_W = 14
);
    logic [ADR_W-1:0] wb_adr;
    logic [31:0]      wb_dat_w;
    logic [3:0]       wb_sel;
    logic             wb_we;
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_ack;
    logic [31:0]      wb_dat_r;

    modport master (
        output wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
        input  wb_ack, wb_dat_r
    );

    modport slave (
        input  wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
        output wb_ack, wb_dat_r
    );
endinterface

// File: rtl/clint_mtime_counter.sv
// Prescaled 64-bit mtime counter with per-half byte-masked load.
module clint_mtime_counter
    import clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] load_data,
    input  logic [3:0]  load_sel,
    output logic [63:0] mtime
);
    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic        tick;

    // Next-state: a load of either half suppresses the whole increment; prescaler runs on.
    always_comb begin
        tick    = (presc_q == PRESCALE_MAX);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        mtime_d = mtime_q;
        if (load_lo || load_hi) begin
            if (load_lo) begin
                mtime_d[31:0] = sel_merge(mtime_q[31:0], load_data, load_sel);
            end
            if (load_hi) begin
                mtime_d[63:32] = sel_merge(mtime_q[63:32], load_data, load_sel);
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= 16'd0;
            mtime_q <= 64'd0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/clint_wb_timer.sv
// CLINT Wishbone responder: msip, mtimecmp, mtime and the derived interrupt lines.
module clint_wb_timer
    import clint_pkg::*;
#(
    parameter int unsigned ADR_W    = 14,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    clint_wb_timer_if.slave  wb,
    output logic             msip_o,
    output logic             mtip_o
);
    clint_state_t state_q, state_d;
    logic [63:0]  mtimecmp_q, mtimecmp_d;
    logic         msip_q, msip_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         mtip_q;
    logic [63:0]  mtime;
    logic [31:0]  rmux;
    logic         access, wr, rd;
    logic         hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;

    // A request is only taken in IDLE, so a held strobe never yields back-to-back acks.
    assign access = (state_q == IDLE) && wb.wb_cyc && wb.wb_stb;
    assign wr     = access && wb.wb_we;
    assign rd     = access && !wb.wb_we;

    assign hit_msip    = (wb.wb_adr == ADR_W'(MSIP_ADR));
    assign hit_cmp_lo  = (wb.wb_adr == ADR_W'(MTIMECMP_LO_ADR));
    assign hit_cmp_hi  = (wb.wb_adr == ADR_W'(MTIMECMP_HI_ADR));
    assign hit_time_lo = (wb.wb_adr == ADR_W'(MTIME_LO_ADR));
    assign hit_time_hi = (wb.wb_adr == ADR_W'(MTIME_HI_ADR));

    clint_mtime_counter #(
        .PRESCALE (PRESCALE)
    ) u_counter (
        .clock     (clock),
        .reset     (reset),
        .load_lo   (wr && hit_time_lo),
        .load_hi   (wr && hit_time_hi),
        .load_data (wb.wb_dat_w),
        .load_sel  (wb.wb_sel),
        .mtime     (mtime)
    );

    // Bus FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (wb.wb_cyc && wb.wb_stb) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read mux of current register values; unmapped addresses read 0.
    always_comb begin
        rmux = 32'd0;
        if (hit_msip)         rmux = {31'd0, msip_q};
        else if (hit_cmp_lo)  rmux = mtimecmp_q[31:0];
        else if (hit_cmp_hi)  rmux = mtimecmp_q[63:32];
        else if (hit_time_lo) rmux = mtime[31:0];
        else if (hit_time_hi) rmux = mtime[63:32];
    end

    // Register writes and read-data capture on the IDLE->ACK edge.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = rdata_q;
        if (wr) begin
            if (hit_msip && wb.wb_sel[0]) msip_d = wb.wb_dat_w[0];
            if (hit_cmp_lo) mtimecmp_d[31:0]  = sel_merge(mtimecmp_q[31:0], wb.wb_dat_w, wb.wb_sel);
            if (hit_cmp_hi) mtimecmp_d[63:32] = sel_merge(mtimecmp_q[63:32], wb.wb_dat_w, wb.wb_sel);
        end
        if (rd) begin
            rdata_d = rmux;
        end
    end

    // State registers; mtip is the compare registered once.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            rdata_q    <= 32'd0;
            mtip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            rdata_q    <= rdata_d;
            mtip_q     <= (mtime >= mtimecmp_q);
        end
    end

    assign wb.wb_ack   = (state_q == ACK);
    assign wb.wb_dat_r = rdata_q;
    assign msip_o      = msip_q;
    assign mtip_o      = mtip_q;

endmodule
